// File: rtl/alu_pipe_n.sv
// alu_pipe_n: two-stage pipelined, width-parameterised eight-operation ALU.
// Stage 1 captures an operand beat; stage 2 computes and holds the result
// until the consumer takes it. A stored carry can be chained into the next
// add or shift so that multi-word arithmetic works across beats.
module alu_pipe_n #(
  parameter int WIDTH = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clr,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             cin_sel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carryout,
  output logic             zero,
  output logic             carry_flag
);

  typedef enum logic [2:0] {
    OpNot  = 3'b000,
    OpAdd  = 3'b001,
    OpAnd  = 3'b010,
    OpOr   = 3'b011,
    OpXor  = 3'b100,
    OpShl  = 3'b101,
    OpZero = 3'b110,
    OpOnes = 3'b111
  } aluOp_e;

  // Stage 1 holding registers
  logic             s1Valid_q;
  aluOp_e           s1Mode_q;
  logic [WIDTH-1:0] s1A_q;
  logic [WIDTH-1:0] s1B_q;
  logic             s1Cin_q;
  logic             s1CinSel_q;

  // Stage 2 / output registers
  logic             outValid_q;
  logic [WIDTH-1:0] result_q;
  logic             carryout_q;
  logic             zero_q;
  logic             carryFlag_q;

  // Stage 2 next-state values computed from the stage 1 registers
  logic [WIDTH-1:0] result_d;
  logic             carryout_d;
  logic             zero_d;
  logic             carryUpdate_d;
  logic             cinEff;
  logic [WIDTH:0]   sumWide;

  // Handshake terms
  logic s2Adv;
  logic s2Load;
  logic inXfer;

  assign s2Adv    = !outValid_q || out_ready;
  assign s2Load   = s1Valid_q && s2Adv;
  assign in_ready = !s1Valid_q || s2Adv;
  assign inXfer   = in_valid && in_ready;

  assign cinEff  = s1CinSel_q ? carryFlag_q : s1Cin_q;
  assign sumWide = {1'b0, s1A_q} + {1'b0, s1B_q} + {{WIDTH{1'b0}}, cinEff};

  // Compute the result of the beat waiting in stage 1
  always_comb begin
    result_d      = '0;
    carryout_d    = 1'b0;
    carryUpdate_d = 1'b0;
    case (s1Mode_q)
      OpNot:  result_d = ~s1A_q;
      OpAdd: begin
        result_d      = sumWide[WIDTH-1:0];
        carryout_d    = sumWide[WIDTH];
        carryUpdate_d = 1'b1;
      end
      OpAnd:  result_d = s1A_q & s1B_q;
      OpOr:   result_d = s1A_q | s1B_q;
      OpXor:  result_d = s1A_q ^ s1B_q;
      OpShl: begin
        result_d      = {s1A_q[WIDTH-2:0], cinEff};
        carryout_d    = s1A_q[WIDTH-1];
        carryUpdate_d = 1'b1;
      end
      OpZero: result_d = '0;
      OpOnes: result_d = '1;
      default: result_d = '0;
    endcase
    zero_d = (result_d == '0);
  end

  // Stage 1: accept a new beat, or empty when its beat moves on to stage 2
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      s1Valid_q  <= 1'b0;
      s1Mode_q   <= OpNot;
      s1A_q      <= '0;
      s1B_q      <= '0;
      s1Cin_q    <= 1'b0;
      s1CinSel_q <= 1'b0;
    end else if (clr) begin
      s1Valid_q <= 1'b0;
    end else if (inXfer) begin
      s1Valid_q  <= 1'b1;
      s1Mode_q   <= aluOp_e'(mode);
      s1A_q      <= a;
      s1B_q      <= b;
      s1Cin_q    <= cin;
      s1CinSel_q <= cin_sel;
    end else if (s2Load) begin
      s1Valid_q <= 1'b0;
    end
  end

  // Stage 2: load a computed result, retire a consumed one, track the carry
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      outValid_q  <= 1'b0;
      result_q    <= '0;
      carryout_q  <= 1'b0;
      zero_q      <= 1'b1;
      carryFlag_q <= 1'b0;
    end else if (clr) begin
      outValid_q  <= 1'b0;
      result_q    <= '0;
      carryout_q  <= 1'b0;
      zero_q      <= 1'b1;
      carryFlag_q <= 1'b0;
    end else if (s2Load) begin
      outValid_q <= 1'b1;
      result_q   <= result_d;
      carryout_q <= carryout_d;
      zero_q     <= zero_d;
      if (carryUpdate_d) begin
        carryFlag_q <= carryout_d;
      end
    end else if (out_ready) begin
      outValid_q <= 1'b0;
    end
  end

  assign out_valid  = outValid_q;
  assign result     = result_q;
  assign carryout   = carryout_q;
  assign zero       = zero_q;
  assign carry_flag = carryFlag_q;

endmodule

// File: tb/tb_alu_pipe_n.sv
// tb_alu_pipe_n: scoreboard bench for alu_pipe_n. A driver pushes the
// expected response of every accepted beat; a monitor pops and compares
// whenever the block hands a result to the consumer.
module tb_alu_pipe_n;

  localparam int W = 4;

  logic         clock = 1'b0;
  logic         reset;
  logic         clr;
  logic         in_valid;
  logic         in_ready;
  logic [2:0]   mode;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         cin_sel;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic         carryout;
  logic         zero;
  logic         carry_flag;

  typedef struct {
    logic [W-1:0] res;
    logic         co;
    logic         z;
  } expect_t;

  expect_t expQ[$];
  logic    modelFlag = 1'b0;
  int      checks = 0;
  int      errors = 0;
  bit      randDone;

  alu_pipe_n #(.WIDTH(W)) dut (
    .clock(clock), .reset(reset), .clr(clr),
    .in_valid(in_valid), .in_ready(in_ready),
    .mode(mode), .a(a), .b(b), .cin(cin), .cin_sel(cin_sel),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .carryout(carryout), .zero(zero),
    .carry_flag(carry_flag)
  );

  // Free-running clock
  always #5 clock = ~clock;

  // Compare one value and report a failure
  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  // Reference ALU from the operation table, using plain integer arithmetic
  function automatic logic [W:0] refOp(input int m, input int av, input int bv, input int cinE);
    int full;
    int s;
    logic [W:0] r;
    full = 1 << W;
    case (m)
      0: s = full - 1 - av;
      1: s = av + bv + cinE;
      2: s = av & bv;
      3: s = av | bv;
      4: s = av ^ bv;
      5: s = av * 2 + cinE;
      6: s = 0;
      default: s = full - 1;
    endcase
    r[W-1:0] = W'(s % full);
    r[W]     = ((m == 1) || (m == 5)) && (s >= full);
    return r;
  endfunction

  // Offer one beat, wait until it is accepted, then record its expected result
  task automatic applyStimulus(input logic [2:0] m, input logic [W-1:0] av, input logic [W-1:0] bv,
                               input logic c, input logic cs);
    int guard;
    int cinE;
    logic [W:0] r;
    expect_t e;
    mode = m; a = av; b = bv; cin = c; cin_sel = cs;
    in_valid = 1'b1;
    guard = 0;
    forever begin
      @(negedge clock);
      if (in_ready) break;
      guard++;
      if (guard > 200) break;
    end
    if (guard > 200) begin
      checks++;
      errors++;
      $display("[TB] FAIL accept_timeout: got in_ready=0 for 200 cycles, required 1");
      in_valid = 1'b0;
      return;
    end
    @(posedge clock);
    cinE = cs ? int'(modelFlag) : int'(c);
    r = refOp(int'(m), int'(av), int'(bv), cinE);
    if ((m == 3'd1) || (m == 3'd5)) modelFlag = r[W];
    e.res = r[W-1:0];
    e.co  = r[W];
    e.z   = (r[W-1:0] == '0);
    expQ.push_back(e);
    #1 in_valid = 1'b0;
  endtask

  // Let the pipeline empty with the consumer ready
  task automatic drain(input string name);
    int g;
    g = 0;
    out_ready = 1'b1;
    while ((expQ.size() != 0 || out_valid) && g < 100) begin
      @(posedge clock);
      g++;
    end
    #1;
    checkOutput(name, 32'(expQ.size()), 32'd0);
  endtask

  // Monitor: score every consumed result and check held results stay stable
  initial begin : monitor
    logic         prevHeld;
    logic [W-1:0] prevRes;
    logic         prevCo;
    logic         prevZ;
    expect_t      e;
    prevHeld = 1'b0;
    prevRes = '0; prevCo = 1'b0; prevZ = 1'b0;
    forever begin
      @(negedge clock);
      if (reset || clr) begin
        prevHeld = 1'b0;
      end else begin
        if (prevHeld) begin
          checkOutput("stall_result", 32'(result), 32'(prevRes));
          checkOutput("stall_carryout", 32'(carryout), 32'(prevCo));
          checkOutput("stall_zero", 32'(zero), 32'(prevZ));
        end
        if (out_valid && out_ready) begin
          if (expQ.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL unexpected_output: got result %0h, required no output", result);
          end else begin
            e = expQ.pop_front();
            checkOutput("sb_result", 32'(result), 32'(e.res));
            checkOutput("sb_carryout", 32'(carryout), 32'(e.co));
            checkOutput("sb_zero", 32'(zero), 32'(e.z));
          end
        end
        prevHeld = out_valid && !out_ready;
        prevRes = result; prevCo = carryout; prevZ = zero;
      end
    end
  end

  // Watchdog so the run always ends
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got simulation still running, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Main directed and random sequence
  initial begin
    logic [3:0] modeRes[8];
    logic       modeCo[8];
    modeRes = '{4'h5, 4'h7, 4'h8, 4'hE, 4'h6, 4'h5, 4'h0, 4'hF};
    modeCo  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};

    reset = 1'b1; clr = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    mode = '0; a = '0; b = '0; cin = 1'b0; cin_sel = 1'b0;
    #2;
    checkOutput("in_ready_in_reset", 32'(in_ready), 32'd1);
    @(negedge clock);
    reset = 1'b0;
    #1;
    checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_result", 32'(result), 32'd0);
    checkOutput("rst_carryout", 32'(carryout), 32'd0);
    checkOutput("rst_zero", 32'(zero), 32'd1);
    checkOutput("rst_carry_flag", 32'(carry_flag), 32'd0);
    checkOutput("rst_in_ready", 32'(in_ready), 32'd1);
    @(posedge clock); #1;

    // Single add that wraps: F + 1
    applyStimulus(3'd1, 4'hF, 4'h1, 1'b0, 1'b0);
    @(posedge clock); #1;
    checkOutput("wrap_out_valid", 32'(out_valid), 32'd1);
    checkOutput("wrap_result", 32'(result), 32'h0);
    checkOutput("wrap_carryout", 32'(carryout), 32'd1);
    checkOutput("wrap_zero", 32'(zero), 32'd1);
    checkOutput("wrap_carry_flag", 32'(carry_flag), 32'd1);
    drain("drain_wrap");

    // Chained add, back to back
    applyStimulus(3'd1, 4'hF, 4'h1, 1'b0, 1'b0);
    applyStimulus(3'd1, 4'h0, 4'h0, 1'b0, 1'b1);
    checkOutput("chain1_result", 32'(result), 32'h0);
    checkOutput("chain1_carryout", 32'(carryout), 32'd1);
    @(posedge clock); #1;
    checkOutput("chain2_result", 32'(result), 32'h1);
    checkOutput("chain2_carryout", 32'(carryout), 32'd0);
    drain("drain_chain");

    // Every mode with a=A, b=C, cin=1
    for (int m = 0; m < 8; m++) begin
      applyStimulus(3'(m), 4'hA, 4'hC, 1'b1, 1'b0);
      @(posedge clock); #1;
      checkOutput($sformatf("mode%0d_result", m), 32'(result), 32'(modeRes[m]));
      checkOutput($sformatf("mode%0d_carryout", m), 32'(carryout), 32'(modeCo[m]));
    end
    drain("drain_modes");

    // Backpressure: only two beats fit while the consumer stalls
    out_ready = 1'b0;
    applyStimulus(3'd4, 4'h3, 4'h5, 1'b0, 1'b0);
    applyStimulus(3'd3, 4'h1, 4'h8, 1'b0, 1'b0);
    mode = 3'd2; a = 4'hF; b = 4'h6; cin = 1'b0; cin_sel = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      checkOutput("bp_in_ready", 32'(in_ready), 32'd0);
      checkOutput("bp_result_held", 32'(result), 32'h6);
    end
    @(posedge clock); #1;
    out_ready = 1'b1;
    applyStimulus(3'd2, 4'hF, 4'h6, 1'b0, 1'b0);
    drain("drain_backpressure");

    // Clear with both stages full and the carry flag set
    out_ready = 1'b0;
    applyStimulus(3'd1, 4'hF, 4'h1, 1'b0, 1'b0);
    applyStimulus(3'd1, 4'hF, 4'h1, 1'b0, 1'b0);
    checkOutput("pre_clr_carry_flag", 32'(carry_flag), 32'd1);
    mode = 3'd7; a = 4'h0; b = 4'h0; in_valid = 1'b1; clr = 1'b1;
    @(posedge clock); #1;
    clr = 1'b0; in_valid = 1'b0;
    expQ.delete();
    modelFlag = 1'b0;
    checkOutput("clr_out_valid", 32'(out_valid), 32'd0);
    checkOutput("clr_carry_flag", 32'(carry_flag), 32'd0);
    checkOutput("clr_in_ready", 32'(in_ready), 32'd1);
    checkOutput("clr_zero", 32'(zero), 32'd1);
    checkOutput("clr_result", 32'(result), 32'h0);
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      checkOutput("clr_stays_empty", 32'(out_valid), 32'd0);
    end
    @(posedge clock); #1;
    mode = 3'd7; in_valid = 1'b1; clr = 1'b1;
    @(posedge clock); #1;
    clr = 1'b0; in_valid = 1'b0;
    @(posedge clock); #1;
    checkOutput("clr_drops_beat", 32'(out_valid), 32'd0);

    // Random streaming with random consumer stalls
    randDone = 1'b0;
    fork
      begin
        for (int i = 0; i < 150; i++) begin
          if ($urandom_range(0, 3) == 0) begin
            @(posedge clock); #1;
          end
          applyStimulus(3'($urandom_range(0, 7)), W'($urandom_range(0, 15)),
                        W'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
                        1'($urandom_range(0, 1)));
        end
        randDone = 1'b1;
      end
      begin
        while (!randDone) begin
          @(posedge clock); #1;
          out_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    drain("drain_random");

    // Asynchronous reset between edges while streaming
    applyStimulus(3'd1, 4'h9, 4'h9, 1'b0, 1'b0);
    applyStimulus(3'd7, 4'h0, 4'h0, 1'b0, 1'b0);
    applyStimulus(3'd4, 4'h5, 4'h3, 1'b0, 1'b0);
    #2 reset = 1'b1;
    #1;
    checkOutput("areset_out_valid", 32'(out_valid), 32'd0);
    checkOutput("areset_result", 32'(result), 32'h0);
    checkOutput("areset_zero", 32'(zero), 32'd1);
    checkOutput("areset_carry_flag", 32'(carry_flag), 32'd0);
    checkOutput("areset_in_ready", 32'(in_ready), 32'd1);
    expQ.delete();
    modelFlag = 1'b0;
    repeat (2) @(negedge clock);
    #1 reset = 1'b0;
    @(posedge clock); #1;
    for (int i = 0; i < 6; i++) begin
      applyStimulus(3'($urandom_range(0, 7)), W'($urandom_range(0, 15)),
                    W'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)));
    end
    drain("drain_after_reset");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_pipe_n.md
# alu_pipe_n

Parametrised, pipelined successor to the team's 4-bit mode-select ALU. It keeps the same eight-operation set but changes three things:
- operand width is a parameter;
- operands and results move through a two-stage pipeline with valid/ready handshakes on both sides;
- a stored carry flag can feed the next operation's carry-in, so wide adds and shifts can be chained across words.

It sits between the operand sequencer and the register-file write port.

## Interface
- WIDTH, 4, operand/result width in bits (≥ 2)
- clock  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset; clears all state
- clr  input  1  synchronous clear: empties both stages, clears carry_flag
- in_valid  input  1  operand beat offered
- in_ready  output  1  block can accept a beat this cycle
- mode  input  3  operation select, see Operation
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- cin  input  1  external carry-in
- cin_sel  input  1  0: use cin; 1: use stored carry_flag
- out_valid  output  1  result register holds an unconsumed result
- out_ready  input  1  consumer takes result this cycle
- result  output  WIDTH  registered result
- carryout  output  1  registered carry of the held result
- zero  output  1  registered, result == 0
- carry_flag  output  1  stored carry, chained into the next op when cin_sel=1

## Operation
- Stage 1 (S1) registers mode, a, b, cin, cin_sel and a valid bit.
- Stage 2 (S2) computes from the S1 registers and loads the result, carryout and zero into the output registers.
- Effective carry-in: cin_eff = cin_sel ? carry_flag : cin, sampled in S2 at compute time.
- Modes:
  - 000: ~A
  - 001: A+B+cin_eff. Sum is taken modulo 2^WIDTH; carryout is bit WIDTH of the sum.
  - 010: A&B
  - 011: A|B
  - 100: A^B
  - 101: shift left, result = {A[WIDTH-2:0], cin_eff}, carryout = A[WIDTH-1]
  - 110: all zeros
  - 111: all ones
- carryout = 0 for every mode except 001 and 101.
- carry_flag takes carryout at the edge a mode-001 or mode-101 result loads into S2. It is unchanged for all other modes and whenever S2 does not load.
- Chained carry is hazard-free: an op's carry_flag update lands at its S2 load edge, which is strictly before the next op computes in S2.
- Handshake:
  - input transfer = in_valid & in_ready;
  - output transfer = out_valid & out_ready;
  - s2_adv = !out_valid | out_ready;
  - in_ready = !s1_valid | s2_adv (combinational, no dependency on in_valid).
- S2 loads when s1_valid & s2_adv.
- out_valid falls after an output transfer if nothing new loads at that edge.
- Input values offered while in_ready=0 are ignored; the producer must hold them.
- result, carryout and zero are stable while out_valid=1 and out_ready=0.

## Timing
- Reset values: out_valid=0, result=0, carryout=0, zero=1, carry_flag=0, S1 empty. in_ready=1 during and after reset.
- Latency: a beat accepted at edge N shows out_valid=1 with its result after edge N+1.
- Throughput: one beat per cycle while out_ready=1.
- Full pipeline: both stages occupied and out_ready=0 drive in_ready=0. The beat in S1 is held intact.
- Simultaneous output transfer and S1→S2 load in the same cycle: out_valid stays 1 and the new result replaces the old one. There is no bubble.
- clr has priority over all transfers at that edge:
  - clears out_valid, s1_valid and carry_flag;
  - forces result=0, carryout=0, zero=1.
  - A beat offered in the same cycle as clr is dropped.
- Asynchronous reset mid-operation discards all in-flight beats immediately, without waiting for a clock edge.
- Data ordering is strictly FIFO. The block never duplicates or drops a beat except on clr or reset.

## Test plan
- WIDTH=4, reset, then mode=001, a=0xF, b=0x1, cin=0 (one beat) -> one cycle later result=0x0, carryout=1, zero=1, carry_flag=1.
- WIDTH=8, chained add: beat 1 a=0xFF, b=0x01, cin_sel=0, cin=0; beat 2 a=0x00, b=0x00, cin_sel=1, sent back-to-back -> results 0x00 (carryout=1) then 0x01 (carryout=0).
- WIDTH=4, each mode 000–111 with a=0xA, b=0xC, cin=1 -> results 0x5, 0x7 (carryout=1), 0x8, 0xE, 0x6, 0x5 (carryout=1), 0x0, 0xF.
- Backpressure: hold out_ready=0 and stream 3 beats -> only 2 are accepted and in_ready=0. Result stays stable. Release out_ready -> all 3 results emerge in order with no loss or duplication.
- clr asserted with both stages full and carry_flag=1 -> next cycle out_valid=0, carry_flag=0, in_ready=1, zero=1. The beat offered during clr never appears.
- Assert reset asynchronously between clock edges during streaming -> outputs take their reset values before the next edge. Streaming resumes correctly after release.
